// File: rtl/otter_intr_ctrl_pkg.sv
// Shared definitions for the OTTER interrupt controller: register offsets
// within the IOBUS block and the presentation state machine encoding.
package otter_intr_pkg;

  localparam logic [31:0] PEND_OFF   = 32'h00;
  localparam logic [31:0] MASK_OFF   = 32'h04;
  localparam logic [31:0] CLAIM_OFF  = 32'h08;
  localparam logic [31:0] ACK_OFF    = 32'h0C;
  localparam logic [31:0] SWTRIG_OFF = 32'h10;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } intr_state_t;

endpackage

// File: rtl/otter_intr_ctrl_if.sv
// IOBUS slice seen by the interrupt controller: CPU address/data/strobe in,
// read data and address-hit flag back out to the wrapper read mux.
interface otter_intr_ctrl_if;

  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;
  logic        RD_HIT;

  modport master (
    output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    input  RD_DATA, RD_HIT
  );

  modport slave (
    input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    output RD_DATA, RD_HIT
  );

endinterface

// File: rtl/otter_intr_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of
// the lowest set bit (bit 0 is the most urgent source).
module intr_prio_enc #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [3:0]         idx
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/otter_intr_ctrl.sv
// Memory-mapped interrupt controller for OTTER: captures rising edges of the
// peripheral sources, masks them, and presents the most urgent one on INTR
// until the CPU acknowledges it, followed by a short quiet period.
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int          NUM_SRC     = 4,
  parameter logic [31:0] BASE_AD     = 32'h11000060,
  parameter int          HOLDOFF_CYC = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] IRQ,
  otter_intr_ctrl_if.slave   bus,
  output logic               INTR,
  output logic [3:0]         CUR_ID
);

  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] prev_irq;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] cur_onehot;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] sw_set;
  logic [31:0]        addr_off;
  logic               wr_mask;
  logic               wr_ack;
  logic               wr_sw;
  logic               ack_match;
  logic               cur_masked_on;
  logic               win_valid;
  logic [3:0]         win_idx;
  logic [7:0]         hold_cnt;
  intr_state_t        state;

  assign addr_off = bus.IOBUS_ADDR - BASE_AD;
  assign wr_mask  = bus.IOBUS_WR && (addr_off == MASK_OFF);
  assign wr_ack   = bus.IOBUS_WR && (addr_off == ACK_OFF);
  assign wr_sw    = bus.IOBUS_WR && (addr_off == SWTRIG_OFF);

  assign cur_onehot    = NUM_SRC'(1) << CUR_ID;
  assign cur_masked_on = |(mask & cur_onehot);
  assign ack_match     = (state == ASSERT) && wr_ack && (bus.IOBUS_OUT[3:0] == CUR_ID);
  assign ack_clr       = ack_match ? cur_onehot : '0;
  assign rise          = IRQ & ~prev_irq;
  assign sw_set        = wr_sw ? bus.IOBUS_OUT[NUM_SRC-1:0] : '0;
  assign active        = pend & mask;

  // Address below the base wraps to a huge offset, so one compare covers both ends
  assign bus.RD_HIT = (addr_off <= SWTRIG_OFF);

  intr_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req   (active),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Register readback is side-effect free; write-only and unused offsets read 0
  always_comb begin
    bus.RD_DATA = '0;
    case (addr_off)
      PEND_OFF:  bus.RD_DATA = 32'(pend);
      MASK_OFF:  bus.RD_DATA = 32'(mask);
      CLAIM_OFF: bus.RD_DATA = {INTR, 27'b0, CUR_ID};
      default:   bus.RD_DATA = '0;
    endcase
  end

  // Edge history, pending bits and mask; new edges and software sets beat an ACK clear
  always_ff @(posedge CLK) begin
    prev_irq <= IRQ;
    if (!RST_N) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= (pend & ~ack_clr) | rise | sw_set;
      if (wr_mask) mask <= bus.IOBUS_OUT[NUM_SRC-1:0];
    end
  end

  // Presentation FSM: pick a winner, hold INTR until ACK or unmask, then stay quiet
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      INTR     <= 1'b0;
      CUR_ID   <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            CUR_ID <= win_idx;
            INTR   <= 1'b1;
            state  <= ASSERT;
          end
        end
        ASSERT: begin
          if (ack_match) begin
            INTR     <= 1'b0;
            hold_cnt <= 8'(HOLDOFF_CYC);
            state    <= HOLDOFF;
          end else if (!cur_masked_on) begin
            INTR  <= 1'b0;
            state <= IDLE;
          end
        end
        HOLDOFF: begin
          INTR <= 1'b0;
          if (hold_cnt <= 8'd1) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          INTR  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Bench for otter_intr_ctrl: directed scenarios with hand-derived expectations,
// then random traffic compared each cycle against a rule-level model.
module tb_otter_intr_ctrl;
  import otter_intr_pkg::*;

  localparam logic [31:0] BASE = 32'h11000060;
  localparam int          HOLD = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] IRQ;
  logic       INTR;
  logic [3:0] CUR_ID;

  int checks = 0;
  int fails  = 0;

  otter_intr_ctrl_if bus ();

  otter_intr_ctrl #(
    .NUM_SRC     (4),
    .BASE_AD     (BASE),
    .HOLDOFF_CYC (HOLD)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .IRQ    (IRQ),
    .bus    (bus),
    .INTR   (INTR),
    .CUR_ID (CUR_ID)
  );

  always #5 CLK = ~CLK;

  // Rule-level model: pending/mask bits, whether a source is being presented,
  // and how many quiet cycles remain after an acknowledge
  logic [3:0] m_pend = '0;
  logic [3:0] m_mask = '0;
  logic [3:0] m_prev = '0;
  logic [3:0] m_cur  = '0;
  logic       m_intr = 1'b0;
  logic       m_presenting = 1'b0;
  int         m_quiet = 0;

  task automatic model_step();
    logic [31:0] off;
    logic [3:0]  nxt_pend;
    logic [3:0]  nxt_mask;
    logic [3:0]  act;
    logic        acked;
    if (!RST_N) begin
      m_pend = '0; m_mask = '0; m_cur = '0; m_intr = 1'b0;
      m_presenting = 1'b0; m_quiet = 0; m_prev = IRQ;
      return;
    end
    off   = bus.IOBUS_ADDR - BASE;
    acked = m_presenting && bus.IOBUS_WR && (off == ACK_OFF) && (bus.IOBUS_OUT[3:0] == m_cur);
    nxt_pend = m_pend;
    if (acked) nxt_pend[m_cur[1:0]] = 1'b0;
    nxt_pend = nxt_pend | (IRQ & ~m_prev);
    if (bus.IOBUS_WR && off == SWTRIG_OFF) nxt_pend = nxt_pend | bus.IOBUS_OUT[3:0];
    nxt_mask = (bus.IOBUS_WR && off == MASK_OFF) ? bus.IOBUS_OUT[3:0] : m_mask;
    act = m_pend & m_mask;
    if (m_presenting) begin
      if (acked) begin
        m_presenting = 1'b0; m_intr = 1'b0; m_quiet = HOLD;
      end else if (!m_mask[m_cur[1:0]]) begin
        m_presenting = 1'b0; m_intr = 1'b0;
      end
    end else if (m_quiet > 0) begin
      m_quiet = m_quiet - 1;
    end else if (act != 4'b0) begin
      for (int i = 3; i >= 0; i--) if (act[i]) m_cur = 4'(i);
      m_presenting = 1'b1; m_intr = 1'b1;
    end
    m_prev = IRQ; m_pend = nxt_pend; m_mask = nxt_mask;
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic h);
    logic [31:0] off;
    off = addr - BASE;
    h   = (off <= 32'h10);
    d   = '0;
    if (off == PEND_OFF)  d = {28'b0, m_pend};
    if (off == MASK_OFF)  d = {28'b0, m_mask};
    if (off == CLAIM_OFF) d = {m_intr, 27'b0, m_cur};
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
    bus.IOBUS_ADDR = BASE + off;
    bus.IOBUS_OUT  = data;
    bus.IOBUS_WR   = 1'b1;
    tick();
    bus.IOBUS_WR   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d, output logic h);
    bus.IOBUS_ADDR = BASE + off;
    bus.IOBUS_WR   = 1'b0;
    #1;
    d = bus.RD_DATA;
    h = bus.RD_HIT;
  endtask

  task automatic drain(input logic [3:0] id);
    bus_write(ACK_OFF, {28'b0, id});
    repeat (HOLD + 2) tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        h;
    RST_N = 1'b0;
    IRQ   = 4'b0010;
    repeat (3) tick();
    checks++; if (INTR !== 1'b0) begin fails++; $display("[TB] FAIL reset_intr: got %b, expected 0", INTR); end
    checks++; if (CUR_ID !== 4'h0) begin fails++; $display("[TB] FAIL reset_cur_id: got %h, expected 0", CUR_ID); end
    rd(PEND_OFF, d, h);
    checks++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL reset_pend: got %h, expected 0", d); end
    rd(MASK_OFF, d, h);
    checks++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL reset_mask: got %h, expected 0", d); end
    RST_N = 1'b1;
    bus_write(MASK_OFF, 32'hF);
    for (int c = 0; c < 10; c++) begin
      rd(PEND_OFF, d, h);
      checks++;
      if (d !== 32'h0 || INTR !== 1'b0) begin
        fails++; $display("[TB] FAIL held_irq_no_fire: got pend=%h intr=%b, expected pend=0 intr=0", d, INTR);
      end
      tick();
    end
    IRQ = 4'b0000;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic        h;
    bus_write(MASK_OFF, 32'h3);
    IRQ = 4'b0010;
    tick();
    IRQ = 4'b0000;
    rd(PEND_OFF, d, h);
    checks++; if (d !== 32'h2) begin fails++; $display("[TB] FAIL basic_pend: got %h, expected 2", d); end
    checks++; if (INTR !== 1'b0) begin fails++; $display("[TB] FAIL basic_intr_early: got %b, expected 0", INTR); end
    tick();
    checks++; if (INTR !== 1'b1 || CUR_ID !== 4'h1) begin
      fails++; $display("[TB] FAIL basic_assert: got intr=%b id=%h, expected intr=1 id=1", INTR, CUR_ID); end
    bus_write(ACK_OFF, 32'h1);
    rd(PEND_OFF, d, h);
    checks++; if (INTR !== 1'b0 || d !== 32'h0) begin
      fails++; $display("[TB] FAIL basic_ack: got intr=%b pend=%h, expected intr=0 pend=0", INTR, d); end
    for (int c = 0; c < HOLD; c++) begin
      tick();
      checks++; if (INTR !== 1'b0) begin fails++; $display("[TB] FAIL basic_holdoff: got %b, expected 0", INTR); end
    end
    tick();
  endtask

  task automatic test_priority();
    logic [31:0] d;
    logic        h;
    int          n;
    bus_write(MASK_OFF, 32'hF);
    IRQ = 4'b1001;
    tick();
    IRQ = 4'b0000;
    tick();
    checks++; if (INTR !== 1'b1 || CUR_ID !== 4'h0) begin
      fails++; $display("[TB] FAIL prio_first: got intr=%b id=%h, expected intr=1 id=0", INTR, CUR_ID); end
    bus_write(ACK_OFF, 32'h0);
    n = 0;
    while (INTR !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n !== HOLD + 1) begin fails++; $display("[TB] FAIL prio_reassert_delay: got %0d, expected %0d", n, HOLD + 1); end
    checks++; if (CUR_ID !== 4'h3) begin fails++; $display("[TB] FAIL prio_second: got %h, expected 3", CUR_ID); end
    bus_write(ACK_OFF, 32'h3);
    rd(PEND_OFF, d, h);
    checks++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL prio_pend_clear: got %h, expected 0", d); end
    repeat (HOLD + 1) tick();
  endtask

  task automatic test_mask_ack_other();
    logic [31:0] d;
    logic        h;
    IRQ = 4'b0100;
    tick();
    IRQ = 4'b0000;
    tick();
    checks++; if (INTR !== 1'b1 || CUR_ID !== 4'h2) begin
      fails++; $display("[TB] FAIL maskack_assert: got intr=%b id=%h, expected intr=1 id=2", INTR, CUR_ID); end
    bus_write(ACK_OFF, 32'h1);
    tick();
    checks++; if (INTR !== 1'b1) begin fails++; $display("[TB] FAIL wrong_id_ack: got %b, expected 1", INTR); end
    bus_write(MASK_OFF, 32'h0);
    tick();
    checks++; if (INTR !== 1'b0) begin fails++; $display("[TB] FAIL unmask_drop: got %b, expected 0", INTR); end
    rd(PEND_OFF, d, h);
    checks++; if (d !== 32'h4) begin fails++; $display("[TB] FAIL unmask_pend_kept: got %h, expected 4", d); end
    bus_write(MASK_OFF, 32'h4);
    tick();
    checks++; if (INTR !== 1'b1 || CUR_ID !== 4'h2) begin
      fails++; $display("[TB] FAIL remask_assert: got intr=%b id=%h, expected intr=1 id=2", INTR, CUR_ID); end
    drain(4'h2);
    bus_write(MASK_OFF, 32'hF);
  endtask

  task automatic test_ack_reedge();
    logic [31:0] d;
    logic        h;
    int          n;
    IRQ = 4'b0100;
    tick();
    IRQ = 4'b0000;
    tick();
    IRQ = 4'b0100;
    bus_write(ACK_OFF, 32'h2);
    IRQ = 4'b0000;
    rd(PEND_OFF, d, h);
    checks++; if (INTR !== 1'b0 || d !== 32'h4) begin
      fails++; $display("[TB] FAIL reedge_ack: got intr=%b pend=%h, expected intr=0 pend=4", INTR, d); end
    n = 0;
    while (INTR !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n !== HOLD + 1 || CUR_ID !== 4'h2) begin
      fails++; $display("[TB] FAIL reedge_reassert: got delay=%0d id=%h, expected delay=%0d id=2", n, CUR_ID, HOLD + 1); end
    drain(4'h2);
  endtask

  task automatic test_swtrig_read();
    logic [31:0] d;
    logic        h;
    bus_write(MASK_OFF, 32'h1);
    bus_write(SWTRIG_OFF, 32'h1);
    checks++; if (INTR !== 1'b0) begin fails++; $display("[TB] FAIL swtrig_early: got %b, expected 0", INTR); end
    tick();
    checks++; if (INTR !== 1'b1) begin fails++; $display("[TB] FAIL swtrig_intr: got %b, expected 1", INTR); end
    rd(CLAIM_OFF, d, h);
    checks++; if (d !== 32'h80000000 || h !== 1'b1) begin
      fails++; $display("[TB] FAIL claim_read: got %h hit=%b, expected 80000000 hit=1", d, h); end
    rd(32'h14, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b0) begin
      fails++; $display("[TB] FAIL past_end_read: got %h hit=%b, expected 0 hit=0", d, h); end
    rd(SWTRIG_OFF, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b1) begin
      fails++; $display("[TB] FAIL swtrig_read: got %h hit=%b, expected 0 hit=1", d, h); end
    tick();
    rd(32'hFFFFFFFC, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b0) begin
      fails++; $display("[TB] FAIL below_base_read: got %h hit=%b, expected 0 hit=0", d, h); end
    drain(4'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        h;
    bus_write(MASK_OFF, 32'hF);
    IRQ = 4'b1000;
    tick();
    IRQ = 4'b0000;
    tick();
    checks++; if (INTR !== 1'b1 || CUR_ID !== 4'h3) begin
      fails++; $display("[TB] FAIL midreset_setup: got intr=%b id=%h, expected intr=1 id=3", INTR, CUR_ID); end
    RST_N = 1'b0;
    tick();
    rd(PEND_OFF, d, h);
    checks++; if (INTR !== 1'b0 || CUR_ID !== 4'h0 || d !== 32'h0) begin
      fails++; $display("[TB] FAIL midreset: got intr=%b id=%h pend=%h, expected all 0", INTR, CUR_ID, d); end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic        h;
    logic [31:0] ed;
    logic        eh;
    logic [31:0] offs [8];
    logic [31:0] wr_offs [5];
    offs    = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'hFFFFFFFC, 32'h2};
    wr_offs = '{PEND_OFF, MASK_OFF, CLAIM_OFF, ACK_OFF, SWTRIG_OFF};
    for (int c = 0; c < 600; c++) begin
      RST_N = ($urandom_range(0, 99) != 0);
      IRQ   = 4'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.IOBUS_ADDR = BASE + wr_offs[$urandom_range(0, 4)];
        bus.IOBUS_OUT  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        bus.IOBUS_WR   = 1'b1;
      end else begin
        bus.IOBUS_ADDR = BASE + offs[$urandom_range(0, 7)];
        bus.IOBUS_OUT  = $urandom;
        bus.IOBUS_WR   = 1'b0;
      end
      #1;
      model_read(bus.IOBUS_ADDR, ed, eh);
      d = bus.RD_DATA;
      h = bus.RD_HIT;
      checks++; if (d !== ed || h !== eh) begin
        fails++; $display("[TB] FAIL rand_read cyc %0d: got %h hit=%b, expected %h hit=%b", c, d, h, ed, eh); end
      tick();
      bus.IOBUS_WR = 1'b0;
      checks++; if (INTR !== m_intr || CUR_ID !== m_cur) begin
        fails++; $display("[TB] FAIL rand_out cyc %0d: got intr=%b id=%h, expected intr=%b id=%h", c, INTR, CUR_ID, m_intr, m_cur); end
    end
    RST_N = 1'b1;
    IRQ   = 4'b0000;
    tick();
  endtask

  initial begin
    RST_N          = 1'b0;
    IRQ            = 4'b0000;
    bus.IOBUS_ADDR = '0;
    bus.IOBUS_OUT  = '0;
    bus.IOBUS_WR   = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_priority();
    test_mask_ack_other();
    test_ack_reedge();
    test_swtrig_read();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
